irq_ctrl: RTL and testbench
===========================

// Module: irq_ctrl
// PURPOSE
//  Interrupt sequencer directly upstream of the CSR unit. Synchronises raw DMA (external) and
//  WDT (timer) interrupt lines, qualifies them with the CSR enables (mstatus.MIE/mie.MTIE/mie.MEIE),
//  and tracks WFI and MRET in EXE. Emits one-shot trap-entry/exit strobes (MEIP_en/MTIP_en,
//  MEIP_end/MTIP_end), the WFI hold (WFI_in to CSR) and a pipeline flush.
// PARAMETERS
//  SYNC_STAGES  2   flops on irq_dma/irq_wdt (0 = pass-through, same clock domain)
//  CNT_W        16  width of saturating taken-trap counter
// PORTS
//  clk        in   1      system clock; all logic on posedge
//  rst        in   1      synchronous, active-high reset
//  irq_dma    in   1      level external interrupt from DMA
//  irq_wdt    in   1      level timer interrupt from WDT
//  mie_in     in   1      mstatus.MIE from CSR (mie_out)
//  meie_in    in   1      mie.MEIE from CSR (meie_out)
//  mtie_in    in   1      mie.MTIE from CSR (mtie_out)
//  inst_E     in   32     instruction in EXE
//  AXI_stall  in   1      bus stall; freezes state, counter and sync chain
//  MEIP_en    out  1      external trap entry strobe
//  MTIP_en    out  1      timer trap entry strobe
//  MEIP_end   out  1      external trap exit strobe
//  MTIP_end   out  1      timer trap exit strobe
//  WFI_out    out  1      WFI hold / pc select to CSR WFI_in; stalls fetch
//  flush      out  1      flush IF/ID/EXE on entry and exit
//  in_handler out  1      high from TRAP through RETURN inclusive
//  trap_cnt   out  CNT_W  traps taken, saturating at all-ones
// BEHAVIOUR
//  Reset: state=IDLE, sync flops, cause_r, trap_cnt cleared; all outputs 0. Reset mid-trap aborts
//   without any *_end strobe.
//  Decode: WFI = inst_E==32'h1050_0073; MRET = inst_E==32'h3020_0073.
//  ext_q = meie_in & dma_s; tmr_q = mtie_in & wdt_s; take = mie_in & (ext_q|tmr_q).
//  Priority: external over timer when both qualify in the same cycle; cause_r latched on entry.
//  AXI_stall=1: no state transition, no counter update, sync chain holds; outputs keep current value.
//  FSM (transitions only when AXI_stall=0):
//   IDLE:     take -> TRAP; else WFI -> WFI_WAIT; take beats WFI in the same cycle.
//   WFI_WAIT: WFI_out=1. take -> TRAP (WFI_out stays 1 in TRAP);
//             (ext_q|tmr_q) & !mie_in -> IDLE (wake, no trap); else stay.
//   TRAP:     1 cycle: MEIP_en=cause_r, MTIP_en=!cause_r, flush=1, trap_cnt++ (sat) -> HANDLER.
//   HANDLER:  interrupts ignored (no nesting); WFI ignored; MRET -> RETURN.
//   RETURN:   1 cycle: MEIP_end=cause_r, MTIP_end=!cause_r, flush=1 -> IDLE.
//  Latency: irq edge to *_en strobe = SYNC_STAGES+1 cycles (no stall, IDLE, enabled).
//  Strobes are Moore outputs of TRAP/RETURN; held through AXI_stall, so CSR samples once.
//  Interrupt still asserted at RETURN->IDLE retraps next cycle (level semantics).
//  At most one of the four strobes is high in any cycle.
// TESTING
//  SYNC_STAGES=2, enables=1, irq_dma 0->1 at cycle 10 -> MEIP_en=1 & flush=1 only at cycle 13.
//  irq_dma & irq_wdt rise same cycle -> MEIP_en only; after MRET, MEIP_end pulse; MTIP_en never.
//  WFI in EXE, irq_wdt at +5 -> WFI_out=1 from +1 until TRAP exits; MTIP_en with WFI_out=1.
//  WFI, mie_in=0, irq_dma=1, meie_in=1 -> WFI_out drops, no strobe, state IDLE.
//  AXI_stall=1 for 3 cycles in TRAP -> MEIP_en held 4 cycles, trap_cnt +1 only.
//  rst in HANDLER -> all outputs 0 next cycle, no *_end; trap_cnt=0; CNT_W=2 saturates at 3.

Source files
------------

// File: rtl/irq_ctrl.sv
// Interrupt sequencer: syncs DMA/WDT lines, qualifies with CSR enables, sequences trap entry/exit.
// Latency: irq edge to *_en strobe = SYNC_STAGES+1 cycles; strobes are Moore outputs of TRAP/RETURN.
// Backpressure: AXI_stall freezes FSM, counter and sync chain; outputs hold their current value.
module irq_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             irq_dma,
  input  logic             irq_wdt,
  input  logic             mie_in,
  input  logic             meie_in,
  input  logic             mtie_in,
  input  logic [31:0]      inst_E,
  input  logic             AXI_stall,
  output logic             MEIP_en,
  output logic             MTIP_en,
  output logic             MEIP_end,
  output logic             MTIP_end,
  output logic             WFI_out,
  output logic             flush,
  output logic             in_handler,
  output logic [CNT_W-1:0] trap_cnt
);

  localparam logic [31:0] WFI_INST  = 32'h1050_0073;
  localparam logic [31:0] MRET_INST = 32'h3020_0073;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WFI,
    S_TRAP,
    S_HANDLER,
    S_RETURN
  } state_t;

  state_t state, state_n;
  logic   cause_r, cause_n;     // 1 = external (DMA), 0 = timer (WDT)
  logic   wfi_hold, wfi_hold_n; // trap was entered from WFI_WAIT
  logic   cnt_inc;
  logic   dma_s, wdt_s;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign dma_s = irq_dma;
      assign wdt_s = irq_wdt;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] dma_ff, wdt_ff;
      always_ff @(posedge clk) begin
        if (rst) begin
          dma_ff <= '0;
          wdt_ff <= '0;
        end else if (!AXI_stall) begin
          dma_ff[0] <= irq_dma;
          wdt_ff[0] <= irq_wdt;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            dma_ff[i] <= dma_ff[i-1];
            wdt_ff[i] <= wdt_ff[i-1];
          end
        end
      end
      assign dma_s = dma_ff[SYNC_STAGES-1];
      assign wdt_s = wdt_ff[SYNC_STAGES-1];
    end
  endgenerate

  logic ext_q, tmr_q, take, is_wfi, is_mret;
  assign ext_q   = meie_in & dma_s;
  assign tmr_q   = mtie_in & wdt_s;
  assign take    = mie_in & (ext_q | tmr_q);
  assign is_wfi  = (inst_E == WFI_INST);
  assign is_mret = (inst_E == MRET_INST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cause_r  <= 1'b0;
      wfi_hold <= 1'b0;
      trap_cnt <= '0;
    end else if (!AXI_stall) begin
      state    <= state_n;
      cause_r  <= cause_n;
      wfi_hold <= wfi_hold_n;
      if (cnt_inc && (trap_cnt != {CNT_W{1'b1}}))
        trap_cnt <= trap_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    state_n    = state;
    cause_n    = cause_r;
    wfi_hold_n = wfi_hold;
    cnt_inc    = 1'b0;
    MEIP_en    = 1'b0;
    MTIP_en    = 1'b0;
    MEIP_end   = 1'b0;
    MTIP_end   = 1'b0;
    WFI_out    = 1'b0;
    flush      = 1'b0;
    in_handler = 1'b0;
    case (state)
      S_IDLE: begin
        if (take) begin
          state_n    = S_TRAP;
          cause_n    = ext_q;
          wfi_hold_n = 1'b0;
        end else if (is_wfi) begin
          state_n = S_WFI;
        end
      end
      S_WFI: begin
        WFI_out = 1'b1;
        if (take) begin
          state_n    = S_TRAP;
          cause_n    = ext_q;
          wfi_hold_n = 1'b1;
        end else if (ext_q | tmr_q) begin
          // pending but globally masked: wake without trapping
          state_n = S_IDLE;
        end
      end
      S_TRAP: begin
        MEIP_en    = cause_r;
        MTIP_en    = !cause_r;
        flush      = 1'b1;
        in_handler = 1'b1;
        WFI_out    = wfi_hold;
        cnt_inc    = 1'b1;
        state_n    = S_HANDLER;
      end
      S_HANDLER: begin
        in_handler = 1'b1;
        if (is_mret) state_n = S_RETURN;
      end
      S_RETURN: begin
        MEIP_end   = cause_r;
        MTIP_end   = !cause_r;
        flush      = 1'b1;
        in_handler = 1'b1;
        state_n    = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: latency, priority, WFI wake/trap, stall hold, retrap, reset, saturation.
module tb_irq_ctrl;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] WFI  = 32'h1050_0073;
  localparam logic [31:0] MRET = 32'h3020_0073;

  logic        clk = 1'b0;
  logic        rst, irq_dma, irq_wdt, mie_in, meie_in, mtie_in, AXI_stall;
  logic [31:0] inst_E;
  logic        MEIP_en, MTIP_en, MEIP_end, MTIP_end, WFI_out, flush, in_handler;
  logic [15:0] trap_cnt;
  logic        MEIP_en2, MTIP_en2, MEIP_end2, MTIP_end2, WFI_out2, flush2, in_handler2;
  logic [1:0]  trap_cnt2;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  irq_ctrl #(.SYNC_STAGES(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .irq_dma(irq_dma), .irq_wdt(irq_wdt), .mie_in(mie_in),
    .meie_in(meie_in), .mtie_in(mtie_in), .inst_E(inst_E), .AXI_stall(AXI_stall),
    .MEIP_en(MEIP_en), .MTIP_en(MTIP_en), .MEIP_end(MEIP_end), .MTIP_end(MTIP_end),
    .WFI_out(WFI_out), .flush(flush), .in_handler(in_handler), .trap_cnt(trap_cnt)
  );

  irq_ctrl #(.SYNC_STAGES(2), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .irq_dma(irq_dma), .irq_wdt(irq_wdt), .mie_in(mie_in),
    .meie_in(meie_in), .mtie_in(mtie_in), .inst_E(inst_E), .AXI_stall(AXI_stall),
    .MEIP_en(MEIP_en2), .MTIP_en(MTIP_en2), .MEIP_end(MEIP_end2), .MTIP_end(MTIP_end2),
    .WFI_out(WFI_out2), .flush(flush2), .in_handler(in_handler2), .trap_cnt(trap_cnt2)
  );

  // Advance one cycle; outputs are sampled and inputs driven 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    vecs++;
    if ({MEIP_en, MTIP_en, MEIP_end, MTIP_end, WFI_out, flush, in_handler} !== 7'b0) begin
      errs++;
      $display("FAIL reset_outs got %b exp 0000000",
               {MEIP_en, MTIP_en, MEIP_end, MTIP_end, WFI_out, flush, in_handler});
    end
    vecs++;
    if (trap_cnt !== 16'd0) begin
      errs++;
      $display("FAIL reset_cnt got %0d exp 0", trap_cnt);
    end
  endtask

  task automatic test_latency();
    logic exp;
    irq_dma = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      exp = (k == 3);
      vecs++;
      if (MEIP_en !== exp || flush !== exp || MTIP_en !== 1'b0) begin
        errs++;
        $display("FAIL latency c+%0d got meip=%b flush=%b mtip=%b exp meip=%b flush=%b mtip=0",
                 k, MEIP_en, flush, MTIP_en, exp, exp);
      end
      if (k == 3) irq_dma = 1'b0;
    end
    inst_E = MRET;
    tick();
    vecs++;
    if (MEIP_end !== 1'b1 || MTIP_end !== 1'b0 || flush !== 1'b1) begin
      errs++;
      $display("FAIL lat_exit got meip_end=%b mtip_end=%b flush=%b exp 1 0 1",
               MEIP_end, MTIP_end, flush);
    end
    inst_E = NOP;
    tick();
    vecs++;
    if (in_handler !== 1'b0 || MEIP_end !== 1'b0 || trap_cnt !== 16'd1) begin
      errs++;
      $display("FAIL lat_idle got in_handler=%b meip_end=%b cnt=%0d exp 0 0 1",
               in_handler, MEIP_end, trap_cnt);
    end
  endtask

  task automatic test_priority();
    logic saw_mtip = 1'b0;
    irq_dma = 1'b1;
    irq_wdt = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      saw_mtip |= MTIP_en;
    end
    vecs++;
    if (MEIP_en !== 1'b1) begin
      errs++;
      $display("FAIL prio_meip got %b exp 1", MEIP_en);
    end
    irq_dma = 1'b0;
    irq_wdt = 1'b0;
    tick(); saw_mtip |= MTIP_en;
    tick(); saw_mtip |= MTIP_en;
    inst_E = MRET;
    tick(); saw_mtip |= MTIP_en;
    vecs++;
    if (MEIP_end !== 1'b1 || MTIP_end !== 1'b0) begin
      errs++;
      $display("FAIL prio_end got meip_end=%b mtip_end=%b exp 1 0", MEIP_end, MTIP_end);
    end
    inst_E = NOP;
    tick(); saw_mtip |= MTIP_en;
    vecs++;
    if (saw_mtip !== 1'b0 || trap_cnt !== 16'd2) begin
      errs++;
      $display("FAIL prio_mtip_never got saw_mtip=%b cnt=%0d exp 0 2", saw_mtip, trap_cnt);
    end
  endtask

  task automatic test_wfi_trap();
    inst_E = WFI;
    tick();
    inst_E = NOP;
    for (int k = 1; k <= 7; k++) begin
      if (k > 1) tick();
      vecs++;
      if (WFI_out !== 1'b1 || MTIP_en !== 1'b0) begin
        errs++;
        $display("FAIL wfi_wait c+%0d got wfi=%b mtip=%b exp 1 0", k, WFI_out, MTIP_en);
      end
      if (k == 5) irq_wdt = 1'b1;
    end
    tick();
    vecs++;
    if (MTIP_en !== 1'b1 || WFI_out !== 1'b1 || MEIP_en !== 1'b0) begin
      errs++;
      $display("FAIL wfi_trap got mtip=%b wfi=%b meip=%b exp 1 1 0", MTIP_en, WFI_out, MEIP_en);
    end
    irq_wdt = 1'b0;
    tick();
    vecs++;
    if (WFI_out !== 1'b0 || in_handler !== 1'b1) begin
      errs++;
      $display("FAIL wfi_handler got wfi=%b in_handler=%b exp 0 1", WFI_out, in_handler);
    end
    tick();
    inst_E = MRET;
    tick();
    vecs++;
    if (MTIP_end !== 1'b1 || MEIP_end !== 1'b0) begin
      errs++;
      $display("FAIL wfi_end got mtip_end=%b meip_end=%b exp 1 0", MTIP_end, MEIP_end);
    end
    inst_E = NOP;
    tick();
  endtask

  task automatic test_wfi_wake();
    logic any_strobe = 1'b0;
    mie_in = 1'b0;
    inst_E = WFI;
    tick();
    inst_E = NOP;
    irq_dma = 1'b1;
    for (int k = 2; k <= 4; k++) begin
      tick();
      any_strobe |= MEIP_en | MTIP_en | MEIP_end | MTIP_end | flush;
      vecs++;
      if (WFI_out !== (k < 4)) begin
        errs++;
        $display("FAIL wake_wfi c+%0d got %b exp %b", k, WFI_out, (k < 4));
      end
    end
    irq_dma = 1'b0;
    tick(); any_strobe |= MEIP_en | MTIP_en | MEIP_end | MTIP_end | flush;
    tick(); any_strobe |= MEIP_en | MTIP_en | MEIP_end | MTIP_end | flush;
    vecs++;
    if (any_strobe !== 1'b0 || in_handler !== 1'b0 || WFI_out !== 1'b0 || trap_cnt !== 16'd3) begin
      errs++;
      $display("FAIL wake_idle got strobe=%b in_handler=%b wfi=%b cnt=%0d exp 0 0 0 3",
               any_strobe, in_handler, WFI_out, trap_cnt);
    end
    mie_in = 1'b1;
  endtask

  task automatic test_stall_retrap();
    int held = 0;
    irq_dma = 1'b1;
    tick(); tick(); tick();
    if (MEIP_en === 1'b1) held++;
    AXI_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (MEIP_en === 1'b1 && flush === 1'b1) held++;
    end
    AXI_stall = 1'b0;
    tick();
    vecs++;
    if (held !== 4 || MEIP_en !== 1'b0 || trap_cnt !== 16'd4) begin
      errs++;
      $display("FAIL stall_hold got held=%0d meip=%b cnt=%0d exp 4 0 4", held, MEIP_en, trap_cnt);
    end
    inst_E = MRET;
    tick();
    vecs++;
    if (MEIP_end !== 1'b1) begin
      errs++;
      $display("FAIL retrap_end got %b exp 1", MEIP_end);
    end
    inst_E = NOP;
    tick();
    vecs++;
    if (in_handler !== 1'b0 || MEIP_en !== 1'b0) begin
      errs++;
      $display("FAIL retrap_idle got in_handler=%b meip=%b exp 0 0", in_handler, MEIP_en);
    end
    tick();
    vecs++;
    if (MEIP_en !== 1'b1 || flush !== 1'b1) begin
      errs++;
      $display("FAIL retrap_again got meip=%b flush=%b exp 1 1", MEIP_en, flush);
    end
    irq_dma = 1'b0;
    tick();
    vecs++;
    if (in_handler !== 1'b1 || trap_cnt !== 16'd5) begin
      errs++;
      $display("FAIL retrap_cnt got in_handler=%b cnt=%0d exp 1 5", in_handler, trap_cnt);
    end
  endtask

  task automatic test_reset_in_handler();
    logic saw_end = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vecs++;
    if ({MEIP_en, MTIP_en, MEIP_end, MTIP_end, WFI_out, flush, in_handler} !== 7'b0 ||
        trap_cnt !== 16'd0) begin
      errs++;
      $display("FAIL rst_handler got outs=%b cnt=%0d exp 0000000 0",
               {MEIP_en, MTIP_en, MEIP_end, MTIP_end, WFI_out, flush, in_handler}, trap_cnt);
    end
    inst_E = MRET;
    for (int k = 0; k < 3; k++) begin
      tick();
      saw_end |= MEIP_end | MTIP_end;
    end
    inst_E = NOP;
    vecs++;
    if (saw_end !== 1'b0) begin
      errs++;
      $display("FAIL rst_no_end got %b exp 0", saw_end);
    end
  endtask

  task automatic test_saturation();
    for (int t = 0; t < 4; t++) begin
      irq_dma = 1'b1;
      tick(); tick(); tick();
      irq_dma = 1'b0;
      tick(); tick();
      inst_E = MRET;
      tick();
      inst_E = NOP;
      tick(); tick();
    end
    vecs++;
    if (trap_cnt2 !== 2'd3) begin
      errs++;
      $display("FAIL sat_cnt2 got %0d exp 3", trap_cnt2);
    end
    vecs++;
    if (trap_cnt !== 16'd4) begin
      errs++;
      $display("FAIL sat_cnt16 got %0d exp 4", trap_cnt);
    end
  endtask

  initial begin
    rst = 1'b1;
    irq_dma = 1'b0;
    irq_wdt = 1'b0;
    mie_in = 1'b1;
    meie_in = 1'b1;
    mtie_in = 1'b1;
    AXI_stall = 1'b0;
    inst_E = NOP;
    test_reset();
    tick(); tick();
    test_latency();
    test_priority();
    test_wfi_trap();
    test_wfi_wake();
    test_stall_retrap();
    test_reset_in_handler();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
